// File: rtl/load_data_unit.sv
// RV32I load data unit: issues one DMEM word read per load and returns the
// aligned, sign/zero-extended result over a valid/ready handshake.
module load_data_unit #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  output logic              dmem_en,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_e              state_q, state_d;
  logic                dmem_en_q, dmem_en_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  function automatic logic load_err(input logic [2:0] f3, input logic [1:0] off);
    logic err;
    unique case (f3)
      F3_LB, F3_LBU: err = 1'b0;
      F3_LH, F3_LHU: err = off[0];
      F3_LW:         err = (off != 2'b00);
      default:       err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] rdata);
    logic [31:0] byte_sh, half_sh, res;
    byte_sh = rdata >> {off, 3'b000};
    half_sh = rdata >> {off[1], 4'b0000};
    unique case (f3)
      F3_LB:   res = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_LBU:  res = {24'b0, byte_sh[7:0]};
      F3_LH:   res = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_LHU:  res = {16'b0, half_sh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    dmem_en_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (load_err(req_funct3, req_addr[1:0])) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'h0;
            state_d      = S_RESP;
          end else begin
            dmem_en_d   = 1'b1;
            dmem_addr_d = req_addr[ADDR_W+1:2];
            cnt_d       = 3'd0;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // cnt_q reaches LAT in the one cycle dmem_rdata is valid.
        if (cnt_q == LAT) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = extract(funct3_q, off_q, dmem_rdata);
          cnt_d        = 3'd0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dmem_en_q    <= 1'b0;
      dmem_addr_q  <= '0;
      cnt_q        <= 3'd0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_en_q    <= dmem_en_d;
      dmem_addr_q  <= dmem_addr_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign dmem_en    = dmem_en_q;
  assign dmem_addr  = dmem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
